// File: rtl/imem_arbiter.sv
// Two-requester arbiter for a single-port, 1-cycle-latency instruction memory.
// The loader has bounded priority over fetch. A fetched HALT_WORD blocks fetch until resume.
module imem_arbiter #(
  parameter int                 ADDR_W         = 16,
  parameter int                 DATA_W         = 32,
  parameter logic [DATA_W-1:0]  HALT_WORD      = 32'hFFFFFFFF,
  parameter int                 LOAD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_valid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              resume,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(LOAD_BURST_MAX + 1);

  // The state records which requester owns the read that returns this cycle.
  typedef enum logic [1:0] {IDLE, F_RD, L_RD} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_nxt;
  logic              halted_nxt;
  logic [ADDR_W-1:0] last_addr;
  logic              f_elig, burst_full;

  assign f_elig     = f_req && !halted && !rst;
  assign burst_full = (burst_cnt == CNT_W'(LOAD_BURST_MAX));
  assign f_valid    = (state == F_RD);
  assign l_valid    = (state == L_RD);
  assign f_rdata    = f_valid ? mem_rdata : '0;
  assign l_rdata    = l_valid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      halted    <= 1'b0;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      halted    <= halted_nxt;
      if (mem_en) last_addr <= mem_addr;
    end
  end

  always_comb begin
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = last_addr;
    mem_wdata  = '0;
    state_nxt  = IDLE;
    burst_nxt  = burst_cnt;
    halted_nxt = halted;

    if (!rst) begin
      if (l_req && !(burst_full && f_elig)) begin
        l_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = l_we;
        mem_addr  = l_addr;
        mem_wdata = l_wdata;
        state_nxt = l_we ? IDLE : L_RD;
      end else if (f_elig) begin
        f_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = f_addr;
        state_nxt = F_RD;
      end
    end

    // The streak counts only loader wins taken while fetch was waiting.
    if (f_gnt || !f_elig)
      burst_nxt = '0;
    else if (l_gnt && !burst_full)
      burst_nxt = burst_cnt + CNT_W'(1);

    // A HALT return takes precedence over a coincident resume.
    if (f_valid && mem_rdata == HALT_WORD)
      halted_nxt = 1'b1;
    else if (resume)
      halted_nxt = 1'b0;
  end
endmodule
